iter_shift_unit: RTL and testbench

- Multi-cycle, parametrised shift/rotate unit with valid/ready handshakes on input and output.
- Serves as the next-generation shifter for the pipelined Mini RISC datapath; it sits beside the ALU in EX.
- Generalises the single-cycle shifter:
  - data width is configurable;
  - the shift is applied up to STEP bit positions per cycle, trading latency for area;
  - adds ROL/ROR, output back-pressure and flush.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_step.sv | 34 +++
 rtl/iter_shift_unit.sv | 121 ++++++++++++
 tb/tb_iter_shift_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared opcodes, FSM state encoding and opcode legality check for the
// iterative shift/rotate unit.
package shift_pkg;

  localparam logic [3:0] OP_SLL = 4'b1101;
  localparam logic [3:0] OP_SRL = 4'b1110;
  localparam logic [3:0] OP_SRA = 4'b1111;
  localparam logic [3:0] OP_ROL = 4'b1011;
  localparam logic [3:0] OP_ROR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by amt_i (0..STEP) positions
// according to op_i. Unknown opcodes pass data through unchanged.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AW-1:0]    amt_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] data_o
);

  // A shift by WIDTH yields zero, so amt_i == 0 leaves rotates intact.
  logic [WIDTH-1:0] rol_w;
  logic [WIDTH-1:0] ror_w;

  always_comb begin
    rol_w  = (data_i << amt_i) | (data_i >> (WIDTH - int'(amt_i)));
    ror_w  = (data_i >> amt_i) | (data_i << (WIDTH - int'(amt_i)));
    data_o = data_i;
    case (op_i)
      OP_SLL:  data_o = data_i << amt_i;
      OP_SRL:  data_o = data_i >> amt_i;
      OP_SRA:  data_o = $signed(data_i) >>> amt_i;
      OP_ROL:  data_o = rol_w;
      OP_ROR:  data_o = ror_w;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift/rotate unit: applies up to STEP positions per cycle,
// valid/ready on both sides, flush aborts any in-flight operation.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       aluOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_out,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on an edge where valid && ready are both
  // high; valid never depends on ready, and ready never depends on valid.

  localparam int AW = $clog2(STEP + 1);
  localparam logic [SHW:0] STEP_EXT = (SHW + 1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic [SHW:0]     k_ext;
  logic [SHW:0]     rem_next;
  logic [WIDTH-1:0] step_out;

  always_comb begin
    k_ext    = ({1'b0, rem_q} > STEP_EXT) ? STEP_EXT : {1'b0, rem_q};
    rem_next = {1'b0, rem_q} - k_ext;
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i (data_q),
    .amt_i  (k_ext[AW-1:0]),
    .op_i   (op_q),
    .data_o (step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    res_d   = res_q;
    // flush wins over acceptance, stepping and the output handshake.
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d = src1;
            rem_d  = shamt;
            op_d   = aluOp;
            if (!is_legal_op(aluOp)) begin
              state_d = DONE;
              res_d   = '0;
            end else if (shamt == '0) begin
              state_d = DONE;
              res_d   = src1;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          data_d = step_out;
          rem_d  = rem_next[SHW-1:0];
          if (rem_next == '0) begin
            state_d = DONE;
            res_d   = step_out;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign shift_out   = res_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: a STEP=4 instance for the main cases and
// a STEP=1 instance for the one-bit-per-cycle latency case.
module tb_iter_shift_unit;
  import shift_pkg::*;

  localparam int W     = 32;
  localparam int LIMIT = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // STEP=4 instance
  logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  src1 = '0;
  logic [4:0]    shamt = '0;
  logic [3:0]    alu_op = '0;
  logic          in_ready, out_valid, busy;
  logic [W-1:0]  shift_out;
  logic [1:0]    dbg_state;

  // STEP=1 instance
  logic          b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [W-1:0]  b_src1 = '0;
  logic [4:0]    b_shamt = '0;
  logic [3:0]    b_alu_op = '0;
  logic          b_in_ready, b_out_valid, b_busy;
  logic [W-1:0]  b_shift_out;
  logic [1:0]    b_dbg_state;

  int checks = 0;
  int failures = 0;

  iter_shift_unit #(.WIDTH(W), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .shamt(shamt), .aluOp(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .shift_out(shift_out), .busy(busy), .dbg_state_o(dbg_state)
  );

  iter_shift_unit #(.WIDTH(W), .STEP(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .src1(b_src1), .shamt(b_shamt), .aluOp(b_alu_op), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .shift_out(b_shift_out), .busy(b_busy), .dbg_state_o(b_dbg_state)
  );

  // driver: present one request (called at posedge+1 while IDLE), then count
  // edges after the accepting edge until out_valid, bounded by LIMIT
  task automatic run_op(input logic [W-1:0] s, input logic [4:0] sh, input logic [3:0] op,
                        output int lat, output logic [W-1:0] res);
    src1 = s; shamt = sh; alu_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = $urandom; shamt = 5'($urandom_range(0, 31)); alu_op = 4'($urandom_range(0, 15));
    lat = 0;
    while (!out_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    res = shift_out;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || shift_out !== '0 ||
        dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b out=%h st=%0d exp rdy=1 vld=0 busy=0 out=0 st=0",
               in_ready, out_valid, busy, shift_out, dbg_state);
    end
  endtask

  task automatic test_shift_ops();
    logic [W-1:0] t_src[7] = '{32'h0000_0001, 32'h8000_00F0, 32'h8000_00F0, 32'h7000_0000,
                               32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    logic [4:0]   t_sh[7]  = '{5'd13, 5'd31, 5'd31, 5'd3, 5'd8, 5'd4, 5'd31};
    logic [3:0]   t_op[7]  = '{OP_SLL, OP_SRA, OP_SRL, OP_SRA, OP_ROR, OP_ROL, OP_ROR};
    logic [W-1:0] t_exp[7] = '{32'h0000_2000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0E00_0000,
                               32'h7812_3456, 32'h2345_6781, 32'h2468_ACF0};
    int           t_lat[7] = '{4, 8, 8, 1, 2, 1, 8};
    int lat;
    logic [W-1:0] res;
    for (int i = 0; i < 7; i++) begin
      run_op(t_src[i], t_sh[i], t_op[i], lat, res);
      checks++;
      if (lat != t_lat[i]) begin
        failures++;
        $display("FAIL op%0d_latency got=%0d exp=%0d", i, lat, t_lat[i]);
      end
      checks++;
      if (res !== t_exp[i]) begin
        failures++;
        $display("FAIL op%0d_result got=%h exp=%h", i, res, t_exp[i]);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL op%0d_done_flags got rdy=%b busy=%b exp rdy=0 busy=1", i, in_ready, busy);
      end
      release_out();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL op%0d_release got vld=%b rdy=%b exp vld=0 rdy=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_zero_illegal();
    int lat;
    logic [W-1:0] res;
    run_op(32'hDEAD_BEEF, 5'd0, OP_SLL, lat, res);
    checks++;
    if (lat != 0 || res !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL zero_shamt got lat=%0d out=%h exp lat=0 out=deadbeef", lat, res);
    end
    release_out();
    run_op(32'hDEAD_BEEF, 5'd5, 4'b0000, lat, res);
    checks++;
    if (lat != 0 || res !== 32'h0) begin
      failures++;
      $display("FAIL illegal_op got lat=%0d out=%h exp lat=0 out=0", lat, res);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] res;
    run_op(32'h0000_000F, 5'd4, OP_SLL, lat, res);
    src1 = 32'h0000_0008; shamt = 5'd2; alu_op = OP_SRL; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (shift_out !== 32'h0000_00F0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold%0d got out=%h rdy=%b vld=%b exp out=f0 rdy=0 vld=1",
                 i, shift_out, in_ready, out_valid);
      end
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL backpressure_bubble got rdy=%b vld=%b st=%0d exp rdy=1 vld=0 st=0",
               in_ready, out_valid, dbg_state);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL waiting_accept got busy=%b exp busy=1", busy);
    end
    lat = 0;
    while (!out_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 1 || shift_out !== 32'h0000_0002) begin
      failures++;
      $display("FAIL waiting_result got lat=%0d out=%h exp lat=1 out=2", lat, shift_out);
    end
    release_out();
  endtask

  task automatic test_flush();
    int seen;
    int lat;
    logic [W-1:0] res;
    src1 = 32'h1; shamt = 5'd20; alu_op = OP_SLL; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (dbg_state !== IDLE || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_shift got st=%0d rdy=%b busy=%b vld=%b exp st=0 rdy=1 busy=0 vld=0",
               dbg_state, in_ready, busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || shift_out !== 32'h0000_0002) begin
      failures++;
      $display("FAIL flush_no_output got vld_cycles=%0d out=%h exp vld_cycles=0 out=2", seen, shift_out);
    end
    src1 = 32'h5; shamt = 5'd1; alu_op = OP_SLL; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_blocks_accept got busy=%b rdy=%b exp busy=0 rdy=1", busy, in_ready);
    end
    run_op(32'h55, 5'd0, OP_SLL, lat, res);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || shift_out !== 32'h55) begin
      failures++;
      $display("FAIL flush_done got vld=%b rdy=%b out=%h exp vld=0 rdy=1 out=55",
               out_valid, in_ready, shift_out);
    end
  endtask

  task automatic test_async_reset();
    src1 = 32'h8000_0000; shamt = 5'd31; alu_op = OP_SRA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || shift_out !== '0) begin
      failures++;
      $display("FAIL async_reset got rdy=%b vld=%b busy=%b out=%h exp rdy=1 vld=0 busy=0 out=0",
               in_ready, out_valid, busy, shift_out);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got busy=%b vld=%b exp busy=0 vld=0", busy, out_valid);
    end
  endtask

  task automatic test_step1();
    int lat;
    b_src1 = 32'h8000_0000; b_shamt = 5'd31; b_alu_op = OP_SRL; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 31 || b_shift_out !== 32'h0000_0001) begin
      failures++;
      $display("FAIL step1_srl31 got lat=%0d out=%h exp lat=31 out=1", lat, b_shift_out);
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL step1_release got rdy=%b vld=%b exp rdy=1 vld=0", b_in_ready, b_out_valid);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    test_shift_ops();
    test_zero_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_step1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
